perlin_scanout_sched: RTL
=========================

PERLIN_SCANOUT_SCHED -- requirements
Module: perlin_scanout_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning span-result buffer entries (power of 2, 2..8).
REQ-002 SHALL have port clk, input, 1, pixel clock (25.175 MHz nominal).
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port pattern_sel, input, 1, requested noise pattern.
REQ-005 SHALL have port req_valid, output, 1, span request valid.
REQ-006 SHALL have port req_ready, input, 1, noise engine accepts request.
REQ-007 SHALL have port req_span, output, 8, span index 0..159 (4 pixels per span).
REQ-008 SHALL have port req_line, output, 9, target visible line 0..479.
REQ-009 SHALL have port req_frame, output, 8, animation frame counter.
REQ-010 SHALL have port req_pattern, output, 1, pattern latched for current frame.
REQ-011 SHALL have port rsp_valid, input, 1, one-cycle response strobe, in request order, no backpressure.
REQ-012 SHALL have port rsp_rrggbb, input, 6, colour of responded span.
REQ-013 SHALL have ports hsync and vsync, output, 1 each, active-low syncs.
REQ-014 SHALL have port rrggbb, output, 6, registered pixel colour.
REQ-015 SHALL have port underrun, output, 1, sticky underrun flag.

Function
REQ-016 SHALL run hcount 0..799 (visible 0..639, sync 656..751) and vcount 0..524 (visible 0..479, sync 490..491); hcount wraps to 0 and increments vcount at 799; vcount wraps at 524.
REQ-017 SHALL register hsync, vsync, rrggbb one cycle after the counters that produce them.
REQ-018 SHALL drive rrggbb 0 whenever hcount>=640 or vcount>=480.
REQ-019 SHALL increment req_frame (mod 256) and latch pattern_sel into req_pattern at hcount==0, vcount==490.
REQ-020 SHALL use FSM IDLE -> FETCH -> DONE -> IDLE.
REQ-021 SHALL move IDLE->FETCH at hcount==640 when next line (vcount+1, or 0 when vcount==524) is visible; set req_line to it, span counter 0.
REQ-022 SHALL in FETCH assert req_valid iff in_flight+buffered < FIFO_DEPTH; a transfer is req_valid&&req_ready; increment req_span per transfer; after span 159 transfers go DONE.
REQ-023 SHALL hold req_span/req_line/req_frame/req_pattern stable while req_valid && !req_ready.
REQ-024 SHALL push rsp_rrggbb into the FIFO on rsp_valid unless discard counter >0, in which case decrement discard and drop the response.
REQ-025 SHALL, on visible pixels, pop one entry when hcount[1:0]==3 and present the head entry for all 4 pixels of the span.
REQ-026 SHALL on an empty FIFO at a visible span (hcount[1:0]==0) output 0 for that span, set underrun, and increment discard by one.
REQ-027 SHALL when push and pop coincide keep occupancy unchanged with the pushed data queued behind the head.
REQ-028 SHALL move DONE->IDLE at hcount==639 and then flush FIFO; discard += remaining in-flight count.
REQ-029 SHALL never overflow: a response with FIFO full SHALL be dropped and set underrun (protocol error).

Reset
REQ-030 SHALL on rst_n low asynchronously clear hcount, vcount, req_frame, req_pattern, FIFO, in-flight and discard counters, underrun, state IDLE, req_valid 0, rrggbb 0, hsync 1, vsync 1.
REQ-031 SHALL clear underrun only by reset.
REQ-032 SHALL, on reset mid-FETCH, drop all state; responses arriving afterwards are ignored until the first new request.

Verification
REQ-033 Release reset, req_ready=1, engine 2-cycle latency -> hsync low hcount 656..751, vsync low vcount 490..491, 160 requests per line, underrun 0.
REQ-034 Engine returns span index as colour -> pixel x shows colour x>>2 for x 0..639, 0 during blanking.
REQ-035 Hold req_ready=0 for line 10 -> line 10 all spans black, underrun 1, line 11 correct colours (alignment restored).
REQ-036 Engine never responds -> req_valid drops after FIFO_DEPTH transfers; no further requests that line.
REQ-037 Toggle pattern_sel mid-frame -> req_pattern changes only at vcount 490 hcount 0; req_frame increments by 1 per frame, 255->0 wrap.
REQ-038 Assert rst_n low during FETCH at span 80 -> all outputs at reset values immediately; next frame fully correct.

Source files
------------

// File: rtl/perlin_scanout_sched.sv
// VGA 640x480 scanout with a span-request scheduler feeding a small colour FIFO from a noise engine.
// Latency: pixel outputs register one cycle after the counters; requests issue one line ahead.
// Backpressure: req_valid holds while req_ready is low; responses cannot be stalled and are dropped on overflow.
module perlin_scanout_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int V_VISIBLE  = 480,
    parameter int V_SYNC_BEG = 490,
    parameter int V_SYNC_END = 491,
    parameter int V_TOTAL    = 525
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pattern_sel,
    output logic       req_valid,
    input  logic       req_ready,
    output logic [7:0] req_span,
    output logic [8:0] req_line,
    output logic [7:0] req_frame,
    output logic       req_pattern,
    input  logic       rsp_valid,
    input  logic [5:0] rsp_rrggbb,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rrggbb,
    output logic       underrun
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SB   = 10'(V_SYNC_BEG);
    localparam logic [9:0] V_SE   = 10'(V_SYNC_END);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t          state;
    logic [9:0]      hcount;
    logic [9:0]      vcount;
    logic [5:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [7:0]      discard;
    logic            span_miss;
    logic            primed;

    logic            h_last, v_last, visible, span_start, span_end;
    logic [9:0]      next_line;
    logic            next_vis, fifo_empty, fifo_full;
    logic            cur_miss, miss_now, pop, xfer, rsp_live;
    logic            disc_drop, push_try, overflow, push, flush;
    logic            fetch_next, fetch_start;
    logic [CW-1:0]   outst_n, count_n;
    logic [CW:0]     occ_n;
    logic [7:0]      discard_n;
    logic [5:0]      pix;

    always_comb begin
        h_last      = (hcount == 10'd799);
        v_last      = (vcount == V_LAST);
        visible     = (hcount < 10'd640) && (vcount < V_VIS);
        span_start  = visible && (hcount[1:0] == 2'd0);
        span_end    = visible && (hcount[1:0] == 2'd3);
        next_line   = v_last ? 10'd0 : vcount + 10'd1;
        next_vis    = (next_line < V_VIS);
        fifo_empty  = (count == '0);
        fifo_full   = (count == CW'(FIFO_DEPTH));

        // A span that starts on an empty FIFO stays black, even if its data shows up late.
        cur_miss    = span_start ? fifo_empty : span_miss;
        miss_now    = span_start && primed && fifo_empty;
        pop         = span_end && !cur_miss;
        pix         = (visible && !cur_miss) ? mem[rd_ptr] : 6'd0;

        xfer        = req_valid && req_ready;
        rsp_live    = rsp_valid && (outstanding != '0);
        disc_drop   = rsp_live && (discard != 8'd0);
        push_try    = rsp_live && (discard == 8'd0);
        overflow    = push_try && fifo_full && !pop;
        push        = push_try && !overflow;
        flush       = (hcount == 10'd639) && (state != IDLE);

        outst_n     = outstanding + CW'(xfer) - CW'(rsp_live);
        count_n     = flush ? '0 : count + CW'(push) - CW'(pop);
        occ_n       = {1'b0, outst_n} + {1'b0, count_n};
        // Misses charged to spans never requested are forgotten at line end; only real stragglers remain.
        discard_n   = flush ? 8'(outst_n) : discard - 8'(disc_drop) + 8'(miss_now);

        fetch_start = (state == IDLE) && (hcount == 10'd640) && next_vis;
        fetch_next  = fetch_start ||
                      ((state == FETCH) && !flush && !(xfer && (req_span == 8'd159)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            rrggbb <= '0;
        end else begin
            if (h_last) begin
                hcount <= '0;
                vcount <= v_last ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 10'd1;
            end
            hsync  <= !((hcount >= 10'd656) && (hcount <= 10'd751));
            vsync  <= !((vcount >= V_SB) && (vcount <= V_SE));
            rrggbb <= pix;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rsp_rrggbb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            span_miss   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count       <= count_n;
            outstanding <= outst_n;
            discard     <= discard_n;
            if (span_start)
                span_miss <= fifo_empty;
            if (miss_now || overflow)
                underrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_valid   <= 1'b0;
            req_span    <= '0;
            req_line    <= '0;
            req_frame   <= '0;
            req_pattern <= 1'b0;
            primed      <= 1'b0;
        end else begin
            if ((hcount == 10'd0) && (vcount == V_SB)) begin
                req_frame   <= req_frame + 8'd1;
                req_pattern <= pattern_sel;
            end
            case (state)
                IDLE: if (fetch_start) begin
                    state    <= FETCH;
                    req_line <= next_line[8:0];
                    req_span <= '0;
                    primed   <= 1'b1;
                end
                FETCH: begin
                    if (flush)
                        state <= IDLE;
                    else if (xfer && (req_span == 8'd159))
                        state <= DONE;
                    else if (xfer)
                        req_span <= req_span + 8'd1;
                end
                DONE: if (flush) state <= IDLE;
                default: state <= IDLE;
            endcase
            req_valid <= fetch_next && (occ_n < (CW+1)'(FIFO_DEPTH));
        end
    end

endmodule
